// File: rtl/jmp_ctrl_bp.sv
// Execute-stage branch/JALR resolution with registered PC redirect,
// a bimodal 2-bit counter table read by fetch, and saturating statistics.
module jmp_ctrl_bp #(
   parameter int         XLEN        = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] CTR_INIT    = 2'b01
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ena,
   input  logic            res_valid,
   input  logic            res_is_branch,
   input  logic            res_is_jalr,
   input  logic [2:0]      res_funct3,
   input  logic [XLEN-1:0] res_pc,
   input  logic [XLEN-1:0] res_imm,
   input  logic [XLEN-1:0] res_rs1,
   input  logic            alu_z,
   input  logic            alu_n,
   input  logic            res_pred_taken,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            stat_clr,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispred_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]      bht_r [BHT_ENTRIES];
   logic            redirect_valid_r;
   logic [XLEN-1:0] redirect_pc_r;
   logic [31:0]     branch_cnt_r;
   logic [31:0]     mispred_cnt_r;

   logic            cond_taken_s;
   logic            cond_legal_s;
   logic            jalr_ev_s;
   logic            br_ev_s;
   logic            redir_s;
   logic [XLEN-1:0] target_s;
   logic [IDX_W-1:0] upd_idx_s;
   logic [IDX_W-1:0] lookup_idx_s;
   logic            unused_s;

   assign upd_idx_s    = res_pc[IDX_W+1:2];
   assign lookup_idx_s = lookup_pc[IDX_W+1:2];
   assign unused_s     = ^{lookup_pc[1:0], lookup_pc[XLEN-1:IDX_W+2]};

   // Branch condition decode; 010/011 are not branches.
   always_comb begin
      cond_taken_s = 1'b0;
      cond_legal_s = 1'b1;
      case (res_funct3)
         3'b000:          cond_taken_s = alu_z;
         3'b001:          cond_taken_s = !alu_z;
         3'b100, 3'b110:  cond_taken_s = alu_n;
         3'b101, 3'b111:  cond_taken_s = !alu_n;
         default: begin
            cond_taken_s = 1'b0;
            cond_legal_s = 1'b0;
         end
      endcase
   end

   // Resolve event classification and redirect target select.
   always_comb begin
      jalr_ev_s = res_valid && ena && res_is_jalr;
      br_ev_s   = res_valid && ena && !res_is_jalr && res_is_branch && cond_legal_s;
      redir_s   = jalr_ev_s || (br_ev_s && (cond_taken_s != res_pred_taken));
      if (res_is_jalr) begin
         target_s = (res_rs1 + res_imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end else if (cond_taken_s) begin
         target_s = res_pc + res_imm;
      end else begin
         target_s = res_pc + XLEN'(4);
      end
   end

   // Redirect register: valid pulses per event, target holds between redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= '0;
      end else begin
         redirect_valid_r <= redir_s;
         if (redir_s) begin
            redirect_pc_r <= target_s;
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt_r  <= 32'd0;
         mispred_cnt_r <= 32'd0;
      end else if (stat_clr) begin
         branch_cnt_r  <= 32'd0;
         mispred_cnt_r <= 32'd0;
      end else begin
         if (br_ev_s && (branch_cnt_r != 32'hFFFF_FFFF)) begin
            branch_cnt_r <= branch_cnt_r + 32'd1;
         end
         if (redir_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 32'd1;
         end
      end
   end

   // Bimodal counter training on legal conditional branches only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_r[i] <= CTR_INIT;
         end
      end else if (br_ev_s) begin
         if (cond_taken_s) begin
            if (bht_r[upd_idx_s] != 2'd3) begin
               bht_r[upd_idx_s] <= bht_r[upd_idx_s] + 2'd1;
            end
         end else if (bht_r[upd_idx_s] != 2'd0) begin
            bht_r[upd_idx_s] <= bht_r[upd_idx_s] - 2'd1;
         end
      end
   end

   assign lookup_taken   = bht_r[lookup_idx_s][1];
   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;
   assign branch_cnt     = branch_cnt_r;
   assign mispred_cnt    = mispred_cnt_r;

endmodule

// File: tb/tb_jmp_ctrl_bp.sv
// Directed self-checking bench for jmp_ctrl_bp with hand-computed expectations.
module tb_jmp_ctrl_bp;

   logic        clk = 1'b0;
   logic        reset;
   logic        ena;
   logic        res_valid;
   logic        res_is_branch;
   logic        res_is_jalr;
   logic [2:0]  res_funct3;
   logic [31:0] res_pc;
   logic [31:0] res_imm;
   logic [31:0] res_rs1;
   logic        alu_z;
   logic        alu_n;
   logic        res_pred_taken;
   logic [31:0] lookup_pc;
   logic        lookup_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stat_clr;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;

   jmp_ctrl_bp dut (
      .clk(clk), .reset(reset), .ena(ena), .res_valid(res_valid),
      .res_is_branch(res_is_branch), .res_is_jalr(res_is_jalr),
      .res_funct3(res_funct3), .res_pc(res_pc), .res_imm(res_imm),
      .res_rs1(res_rs1), .alu_z(alu_z), .alu_n(alu_n),
      .res_pred_taken(res_pred_taken), .lookup_pc(lookup_pc),
      .lookup_taken(lookup_taken), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stat_clr(stat_clr),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic jalr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic z, input logic n, input logic pred);
      res_valid = 1'b1; res_is_branch = br; res_is_jalr = jalr; res_funct3 = f3;
      res_pc = pc; res_imm = imm; res_rs1 = rs1; alu_z = z; alu_n = n; res_pred_taken = pred;
   endtask

   task automatic idle();
      res_valid = 1'b0; res_is_branch = 1'b0; res_is_jalr = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp);
      lookup_pc = pc;
      #1;
      check(tag, {31'd0, lookup_taken}, {31'd0, exp});
   endtask

   task automatic state(input string tag, input logic rv, input logic [31:0] rpc,
                        input logic [31:0] br, input logic [31:0] mis);
      check({tag, "_rv"},  {31'd0, redirect_valid}, {31'd0, rv});
      check({tag, "_rpc"}, redirect_pc, rpc);
      check({tag, "_br"},  branch_cnt, br);
      check({tag, "_mis"}, mispred_cnt, mis);
   endtask

   initial begin
      reset = 1'b1; ena = 1'b1; stat_clr = 1'b0; lookup_pc = 32'd0;
      res_funct3 = 3'd0; res_pc = 32'd0; res_imm = 32'd0; res_rs1 = 32'd0;
      alu_z = 1'b0; alu_n = 1'b0; res_pred_taken = 1'b0;
      idle();
      step(); step();
      state("in_reset", 1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      state("post_reset", 1'b0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < 64; i++) look("lookup_reset", i * 4, 1'b0);

      // BNE mispredict; same-cycle lookup sees pre-update counter
      drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
      look("lookup_pre_update", 32'h100, 1'b0);
      step();
      state("bne_mis", 1'b1, 32'h120, 32'd1, 32'd1);
      look("bne_bht2", 32'h100, 1'b1);
      idle();
      step();
      state("bne_pulse_end", 1'b0, 32'h120, 32'd1, 32'd1);

      // BGE correctly predicted taken, twice: counter 2 -> 3 -> 3
      drive(1'b1, 1'b0, 3'b101, 32'h100, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      state("bge_ok1", 1'b0, 32'h120, 32'd2, 32'd1);
      step();
      state("bge_ok2", 1'b0, 32'h120, 32'd3, 32'd1);
      // correct not-taken: 3 -> 2 (still taken) -> 1 (not taken)
      drive(1'b1, 1'b0, 3'b101, 32'h100, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      look("bht_sat_dec1", 32'h100, 1'b1);
      step();
      look("bht_sat_dec2", 32'h100, 1'b0);
      state("bge_nt", 1'b0, 32'h120, 32'd5, 32'd1);

      // back-to-back mispredicts: BLT taken backwards, then BLTU not taken
      drive(1'b1, 1'b0, 3'b100, 32'h204, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      state("blt_mis", 1'b1, 32'h1FC, 32'd6, 32'd2);
      look("blt_bht", 32'h204, 1'b1);
      drive(1'b1, 1'b0, 3'b110, 32'h308, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      state("bltu_mis", 1'b1, 32'h30C, 32'd7, 32'd3);
      drive(1'b1, 1'b0, 3'b000, 32'h308, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1);
      step();
      state("beq_ok", 1'b0, 32'h30C, 32'd8, 32'd3);
      drive(1'b1, 1'b0, 3'b111, 32'h40C, 32'h80, 32'h0, 1'b0, 1'b1, 1'b1);
      step();
      state("bgeu_mis", 1'b1, 32'h410, 32'd9, 32'd4);

      // JALR has priority over the branch flag; BHT untouched
      drive(1'b1, 1'b1, 3'b000, 32'h100, 32'h4, 32'h1003, 1'b1, 1'b0, 1'b1);
      step();
      state("jalr", 1'b1, 32'h1006, 32'd9, 32'd5);
      look("jalr_bht", 32'h100, 1'b0);

      // ena low, illegal funct3, and non-branch: no effect
      ena = 1'b0;
      drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      state("ena_off", 1'b0, 32'h1006, 32'd9, 32'd5);
      look("ena_off_bht", 32'h100, 1'b0);
      ena = 1'b1;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      state("illegal_f3", 1'b0, 32'h1006, 32'd9, 32'd5);
      look("illegal_bht", 32'h100, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      state("not_branch", 1'b0, 32'h1006, 32'd9, 32'd5);

      // saturation: preload near max, then a mispredict stream
      idle();
      force dut.mispred_cnt_r = 32'hFFFF_FFFE;
      force dut.branch_cnt_r  = 32'hFFFF_FFFE;
      #1;
      release dut.mispred_cnt_r;
      release dut.branch_cnt_r;
      drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      state("sat1", 1'b1, 32'h120, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      state("sat2", 1'b1, 32'h120, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      stat_clr = 1'b1;
      step();
      state("clr_vs_inc", 1'b1, 32'h120, 32'd0, 32'd0);
      stat_clr = 1'b0;
      step();
      state("after_clr", 1'b1, 32'h120, 32'd1, 32'd1);
      ena = 1'b0; stat_clr = 1'b1;
      step();
      state("clr_ena_off", 1'b0, 32'h120, 32'd0, 32'd0);
      ena = 1'b1; stat_clr = 1'b0;

      // asynchronous reset drops a live redirect pulse
      drive(1'b1, 1'b0, 3'b001, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("pre_async_rv", {31'd0, redirect_valid}, 32'd1);
      idle();
      #1 reset = 1'b1;
      #1;
      state("async_reset", 1'b0, 32'd0, 32'd0, 32'd0);
      look("async_reset_bht", 32'h100, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("post_async_rv", {31'd0, redirect_valid}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/jmp_ctrl_bp.md
# jmp_ctrl_bp

Parametrised branch-resolution and redirect unit with an integrated bimodal branch-history table (BHT). It sits at the execute stage of the core. It resolves conditional branches and JALR, and compares each outcome with the fetch-stage prediction. When they disagree it issues a registered PC redirect. It also trains a table of 2-bit saturating counters that fetch reads combinationally, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32: datapath and PC width.
- BHT_ENTRIES, 64: number of counters; power of two, 2..1024. IDX_W = log2(BHT_ENTRIES).
- CTR_INIT, 2'b01: counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- ena  in  1  stage enable; when low, resolve is ignored and no state changes except stat_clr.
- res_valid  in  1  an instruction is being resolved this cycle.
- res_is_branch  in  1  conditional branch (B-type).
- res_is_jalr  in  1  JALR; has priority over res_is_branch.
- res_funct3  in  3  branch funct3.
- res_pc  in  XLEN  PC of the resolving instruction.
- res_imm  in  XLEN  sign-extended immediate.
- res_rs1  in  XLEN  rs1 value.
- alu_z  in  1  compare result is zero (rs1 == rs2).
- alu_n  in  1  less-than result; ALU selects signed or unsigned from funct3[1].
- res_pred_taken  in  1  prediction fetch made for this instruction.
- lookup_pc  in  XLEN  fetch PC.
- lookup_taken  out  1  combinational MSB of the counter indexed by lookup_pc.
- redirect_valid  out  1  registered; fetch must load redirect_pc.
- redirect_pc  out  XLEN  registered redirect target.
- stat_clr  in  1  synchronous clear of both statistics counters.
- branch_cnt  out  32  saturating count of resolved conditional branches.
- mispred_cnt  out  32  saturating count of redirects, including JALR.

## Operation
- Index: idx(pc) = pc[IDX_W+1:2].
- Condition decode:
  - 000 beq: taken = alu_z.
  - 001 bne: taken = !alu_z.
  - 100 blt / 110 bltu: taken = alu_n.
  - 101 bge / 111 bgeu: taken = !alu_n.
  - 010 and 011 are illegal: taken = 0, no BHT update, no statistics update, no redirect.
- Targets:
  - branch target = res_pc + res_imm.
  - JALR target = (res_rs1 + res_imm) & ~1.
  - fall-through = res_pc + 4.
  - All arithmetic is modulo 2^XLEN.
- A resolve event fires when res_valid && ena. On an event:
  - JALR: redirect to the JALR target unconditionally; mispred_cnt increments; BHT untouched.
  - Legal branch with taken != res_pred_taken: redirect to the branch target if taken, otherwise to fall-through; mispred_cnt increments.
  - Legal branch: branch_cnt increments; BHT[idx(res_pc)] increments on taken (saturate at 3) or decrements on not-taken (saturate at 0).
  - Neither branch nor JALR: no action.
- Redirect register: redirect_valid is loaded every clock with the redirect decision. It is 0 whenever there is no resolve event, including when ena = 0. redirect_pc updates only when a redirect occurs; otherwise it holds.
- Statistics: both counters stick at 0xFFFFFFFF. stat_clr has priority over a same-cycle increment, so the result is 0.

## Timing
- Reset, asynchronous: redirect_valid = 0, redirect_pc = 0, branch_cnt = 0, mispred_cnt = 0, all BHT entries = CTR_INIT. lookup_taken then reads CTR_INIT[1].
- Redirect latency: one cycle; inputs at edge N appear on the outputs after edge N.
- A redirect pulse lasts exactly one cycle per event. Back-to-back events give back-to-back pulses.
- BHT write takes effect at the edge. A lookup in the same cycle as an update to the same index returns the pre-update value.
- Reset asserted mid-stream clears a pending redirect immediately, without waiting for a clock edge.

## Test plan
- Reset: assert reset, then release. Required: redirect_valid = 0, counters = 0, and lookup_taken = 0 for every index.
- BNE mispredict:
  - Stimulus: res_pc = 0x100, imm = 0x20, funct3 = 001, alu_z = 0, pred_taken = 0.
  - Next cycle: redirect_valid = 1, redirect_pc = 0x120, mispred_cnt = 1, branch_cnt = 1.
  - BHT[0x40 & (BHT_ENTRIES-1)] = 2, so lookup_taken = 1 at that index.
- BGE correctly predicted:
  - Stimulus: pred_taken = 1, funct3 = 101, alu_n = 0.
  - Required: no redirect, branch_cnt increments, counter saturates at 3 after repeated taken.
- JALR: rs1 = 0x1003, imm = 0x4. Required: redirect_pc = 0x1006, mispred_cnt increments, BHT unchanged.
- ena = 0 or funct3 = 010 with res_valid = 1. Required: no redirect, no counter change, no BHT change.
- Saturation and clear:
  - Preload mispred_cnt to 0xFFFFFFFF via a long mispredict stream; it stays at 0xFFFFFFFF.
  - stat_clr concurrent with a mispredict gives 0.
  - Reset asserted the same cycle as redirect_valid = 1 drops it immediately.
